// File: rtl/jtkcpu_stack_pkg.sv
// jtkcpu_stack_pkg
//   Shared types and constants for the push/pull stack sequencer.
//   - state_t : sequencer states
//   - dbg_t   : state snapshot exported for checkers (state, direction, stack, mask)
//   - mask constants for the fixed interrupt / RTI masks
//   - is_wide : register-select decode, 1 for the 16-bit registers (X, Y, other SP, PC)
package jtkcpu_stack_pkg;

  // Register-select / mask-bit numbering: 0 CC, 1 A, 2 B, 3 DP, 4 X, 5 Y, 6 other SP, 7 PC
  localparam logic [2:0] REG_X = 3'd4;   // first 16-bit register

  localparam logic [7:0] MASK_ALL   = 8'hFF;  // interrupt entry: everything
  localparam logic [7:0] MASK_CC    = 8'h01;  // RTI, CC only
  localparam logic [7:0] MASK_RTI_E = 8'hFE;  // RTI with E set: all but CC
  localparam logic [7:0] MASK_PC    = 8'h80;  // RTI with E clear: PC only

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PSEL = 3'd1,
    ST_WLO  = 3'd2,
    ST_WHI  = 3'd3,
    ST_RHI  = 3'd4,
    ST_RLO  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  typedef struct packed {
    state_t      state;
    logic        push;
    logic        use_u;
    logic [7:0]  mask;
  } dbg_t;

  function automatic logic is_wide(input logic [2:0] sel);
    return sel >= REG_X;
  endfunction

endpackage

// File: rtl/jtkcpu_stack_if.sv
// jtkcpu_stack_if
//   Byte-wide memory bus between the stack sequencer (master) and memory (slave).
//   - addr, dout : address and write data, driven by the master
//   - we, rd     : write / read strobes, at most one high at a time
//   - mem_busy   : memory wait request
//   - din        : read data
//   Handshake: the master holds a strobe together with addr/dout steady. The access
//   completes on the first clock edge with cen=1 where the strobe is high and mem_busy
//   is low; on a read, din must be valid in that same cycle. mem_busy low while no strobe
//   is asserted has no meaning.
interface jtkcpu_stack_if;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        we;
  logic        rd;
  logic        mem_busy;
  logic [7:0]  din;

  modport master (output addr, dout, we, rd, input mem_busy, din);
  modport slave  (input addr, dout, we, rd, output mem_busy, din);
endinterface

// File: rtl/jtkcpu_stack_penc.sv
// jtkcpu_stack_penc
//   8-bit priority encoder with a direction select.
//   - mask     in  8 : candidate bits
//   - from_top in  1 : 1 picks the highest set bit, 0 picks the lowest
//   - idx      out 3 : selected bit index (0 when mask is empty)
//   - valid    out 1 : mask has at least one set bit
module jtkcpu_stack_penc (
  input  logic [7:0] mask,
  input  logic       from_top,
  output logic [2:0] idx,
  output logic       valid
);

  // Scan in the opposite order of priority so the last hit wins.
  always_comb begin
    idx   = 3'd0;
    valid = |mask;
    if (from_top) begin
      for (int i = 0; i < 8; i++)
        if (mask[i]) idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (mask[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/jtkcpu_stack.sv
// jtkcpu_stack
//   Push/pull sequencer driven by the microcode. Walks a register mask one byte per
//   memory access, reading the register file for pushes and assembling pulled values
//   for it. stack_busy stays high for the whole transfer so the microcode stalls.
//   Ports:
//   - clk, rst (sync, active high), cen (clock enable)
//   - psh_go / pul_go    : start pulses, only honoured while idle (push wins a tie)
//   - psh_all, psh_cc, psh_pc, rti_cc, rti_other, cc_e, postbyte : mask selection
//   - use_u              : which stack is the pointer (recorded for debug)
//   - sp                 : stack pointer value loaded at start
//   - rdata              : register-file read data for reg_sel
//   - bus                : memory bus (addr, dout, we, rd, mem_busy, din)
//   - stack_busy         : transfer active
//   - reg_sel            : register being transferred
//   - reg_we / wdata     : register-file load pulse and pulled value
//   - sp_we / nx_sp      : stack-pointer load pulse and updated pointer
//   - dbg                : state, direction, stack and remaining mask
module jtkcpu_stack
  import jtkcpu_stack_pkg::*;
#(
  parameter int SP_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  input  logic                 psh_go,
  input  logic                 pul_go,
  input  logic                 psh_all,
  input  logic                 psh_cc,
  input  logic                 psh_pc,
  input  logic                 rti_cc,
  input  logic                 rti_other,
  input  logic                 cc_e,
  input  logic [7:0]           postbyte,
  input  logic                 use_u,
  input  logic [15:0]          sp,
  input  logic [15:0]          rdata,
  jtkcpu_stack_if.master       bus,
  output logic                 stack_busy,
  output logic [2:0]           reg_sel,
  output logic                 reg_we,
  output logic [15:0]          wdata,
  output logic                 sp_we,
  output logic [15:0]          nx_sp,
  output dbg_t                 dbg
);

  localparam logic [15:0] STEP = 16'(SP_STEP);

  state_t      state, nx_state;
  logic [7:0]  mask;
  logic [15:0] ptr;
  logic [2:0]  sel;
  logic        push;
  logic        stk_u;
  logic [15:0] wdata_r;
  logic        reg_we_r;
  logic [2:0]  pe_idx;
  logic        pe_valid;

  // Pushes go PC first (highest bit), pulls go CC first (lowest bit).
  jtkcpu_stack_penc u_penc (
    .mask     (mask),
    .from_top (push),
    .idx      (pe_idx),
    .valid    (pe_valid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst)      state <= ST_IDLE;
    else          state <= nx_state;
  end

  // Next state
  always_comb begin
    nx_state = state;
    if (cen) begin
      case (state)
        ST_IDLE: if (psh_go || pul_go) nx_state = ST_PSEL;
        ST_PSEL: begin
          if (!pe_valid)             nx_state = ST_DONE;
          else if (push)             nx_state = ST_WLO;
          else if (is_wide(pe_idx))  nx_state = ST_RHI;
          else                       nx_state = ST_RLO;
        end
        ST_WLO:  if (!bus.mem_busy) nx_state = is_wide(sel) ? ST_WHI : ST_PSEL;
        ST_WHI:  if (!bus.mem_busy) nx_state = ST_PSEL;
        ST_RHI:  if (!bus.mem_busy) nx_state = ST_RLO;
        ST_RLO:  if (!bus.mem_busy) nx_state = ST_PSEL;
        ST_DONE:                    nx_state = ST_IDLE;
        default:                    nx_state = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the state. Pushes predecrement, so the write address is ptr-1;
  // pulls postincrement, so the read address is ptr itself.
  always_comb begin
    bus.addr = 16'h0000;
    bus.dout = 8'h00;
    bus.we   = 1'b0;
    bus.rd   = 1'b0;
    sp_we    = 1'b0;
    case (state)
      ST_WLO: begin
        bus.addr = ptr - STEP;
        bus.dout = rdata[7:0];
        bus.we   = 1'b1;
      end
      ST_WHI: begin
        bus.addr = ptr - STEP;
        bus.dout = rdata[15:8];
        bus.we   = 1'b1;
      end
      ST_RHI, ST_RLO: begin
        bus.addr = ptr;
        bus.rd   = 1'b1;
      end
      ST_DONE: sp_we = 1'b1;
      default: ;
    endcase
  end

  // Datapath: mask, pointer, selected register and pulled-value assembly.
  // sel only moves in PSEL, so reg_sel still names the finished register while the
  // reg_we pulse that follows its last byte is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask     <= 8'h00;
      ptr      <= 16'h0000;
      sel      <= 3'd0;
      push     <= 1'b0;
      stk_u    <= 1'b0;
      wdata_r  <= 16'h0000;
      reg_we_r <= 1'b0;
    end else if (cen) begin
      reg_we_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (psh_go) begin
            push  <= 1'b1;
            ptr   <= sp;
            stk_u <= use_u;
            mask  <= psh_all ? MASK_ALL : (postbyte | {psh_pc, 6'b000000, psh_cc});
          end else if (pul_go) begin
            push  <= 1'b0;
            ptr   <= sp;
            stk_u <= use_u;
            mask  <= rti_cc ? MASK_CC : rti_other ? (cc_e ? MASK_RTI_E : MASK_PC) : postbyte;
          end
        end
        ST_PSEL: if (pe_valid) sel <= pe_idx;
        ST_WLO: if (!bus.mem_busy) begin
          ptr <= ptr - STEP;
          if (!is_wide(sel)) mask[sel] <= 1'b0;
        end
        ST_WHI: if (!bus.mem_busy) begin
          ptr       <= ptr - STEP;
          mask[sel] <= 1'b0;
        end
        ST_RHI: if (!bus.mem_busy) begin
          wdata_r[15:8] <= bus.din;
          ptr           <= ptr + STEP;
        end
        ST_RLO: if (!bus.mem_busy) begin
          wdata_r[7:0] <= bus.din;
          if (!is_wide(sel)) wdata_r[15:8] <= 8'h00;
          ptr       <= ptr + STEP;
          mask[sel] <= 1'b0;
          reg_we_r  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stack_busy = (state != ST_IDLE);
  assign reg_sel    = sel;
  assign reg_we     = reg_we_r;
  assign wdata      = wdata_r;
  assign nx_sp      = ptr;
  assign dbg        = '{state: state, push: push, use_u: stk_u, mask: mask};

endmodule

// File: tb/tb_jtkcpu_stack.sv
module tb_jtkcpu_stack;
  import jtkcpu_stack_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk, rst, cen;
  logic        psh_go, pul_go, psh_all, psh_cc, psh_pc, rti_cc, rti_other, cc_e, use_u;
  logic [7:0]  postbyte;
  logic [15:0] sp, rdata;
  logic        stack_busy, reg_we, sp_we;
  logic [2:0]  reg_sel;
  logic [15:0] wdata, nx_sp;
  dbg_t        dbg;

  jtkcpu_stack_if bus();

  jtkcpu_stack #(.SP_STEP(1)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .psh_go(psh_go), .pul_go(pul_go), .psh_all(psh_all), .psh_cc(psh_cc), .psh_pc(psh_pc),
    .rti_cc(rti_cc), .rti_other(rti_other), .cc_e(cc_e), .postbyte(postbyte), .use_u(use_u),
    .sp(sp), .rdata(rdata), .bus(bus),
    .stack_busy(stack_busy), .reg_sel(reg_sel), .reg_we(reg_we), .wdata(wdata),
    .sp_we(sp_we), .nx_sp(nx_sp), .dbg(dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected summary earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- environment state ----------------
  logic [15:0] reg_val [8];      // register file contents seen by pushes
  logic [15:0] pulled  [8];      // values loaded by reg_we
  logic [7:0]  mem [0:65535];    // memory device
  logic [24:0] exp_q[$];         // {we, addr, data} in bus order
  logic [18:0] exp_r[$];         // {reg_sel, value} in reg_we order
  logic [15:0] exp_sp;
  int          n_cmp = 0, n_bad = 0;
  int          n_wr = 0, n_rd = 0, n_rwe = 0, n_done = 0, busy_cyc = 0;
  int          d_wr, d_rd, d_rwe, d_busy;
  logic [15:0] last_sp = 16'h0000;
  int          wait_n = 0;
  bit          cen_rand = 0;
  bit          completing = 0, comp_we = 0;
  logic [15:0] comp_addr = 16'h0000;
  logic [7:0]  comp_dout = 8'h00;

  always_comb rdata = reg_val[reg_sel];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory device: wait states, writes, read data ----------------
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_busy = 1'b0;
    bus.din = 8'h00;
    cen = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (completing && comp_we) mem[comp_addr] = comp_dout;
      if (completing) wcnt = 0;
      cen = cen_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!(bus.we || bus.rd)) begin
        bus.mem_busy = 1'b0;
        wcnt = 0;
      end else if (cen) begin
        if (wcnt < wait_n) begin
          bus.mem_busy = 1'b1;
          wcnt++;
        end else begin
          bus.mem_busy = 1'b0;
        end
      end
      bus.din = mem[bus.addr];
    end
  end

  // ---------------- compare process (scoreboard) ----------------
  initial begin
    logic [63:0] cur, prev;
    logic        prev_cen, prev_rst;
    logic [24:0] e;
    logic [18:0] r;
    prev = '0;
    prev_cen = 1'b1;
    prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      cur = {24'h0, bus.we, bus.rd, reg_we, sp_we, stack_busy, reg_sel, bus.addr, bus.dout, nx_sp};
      completing = 1'b0;
      if (!rst) begin
        chk("idle_quiet", 64'((bus.we | bus.rd | sp_we) & ~stack_busy), 64'd0);
        if (bus.we || bus.rd) chk("strobe_excl", 64'(bus.we & bus.rd), 64'd0);
        if (!prev_rst && !prev_cen) chk("cen_hold", cur, prev);
        if (cen && (bus.we || bus.rd) && !bus.mem_busy) begin
          completing = 1'b1;
          comp_we    = bus.we;
          comp_addr  = bus.addr;
          comp_dout  = bus.dout;
          if (exp_q.size() == 0) begin
            chk("extra_access", {47'h0, bus.we, bus.addr}, 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            chk("acc_kind", 64'(bus.we), 64'(e[24]));
            chk("acc_addr", 64'(bus.addr), 64'(e[23:8]));
            if (bus.we) chk("acc_data", 64'(bus.dout), 64'(e[7:0]));
          end
          if (bus.we) n_wr++; else n_rd++;
        end
        if (cen && reg_we) begin
          if (exp_r.size() == 0) begin
            chk("extra_reg_we", 64'(reg_sel), 64'hDEAD);
          end else begin
            r = exp_r.pop_front();
            chk("reg_sel", 64'(reg_sel), 64'(r[18:16]));
            chk("wdata", 64'(wdata), 64'(r[15:0]));
          end
          pulled[reg_sel] = wdata;
          n_rwe++;
        end
        if (cen && sp_we) begin
          chk("nx_sp", 64'(nx_sp), 64'(exp_sp));
          chk("acc_left_at_done", 64'(exp_q.size()), 64'd0);
          last_sp = nx_sp;
          n_done++;
        end
        if (cen && stack_busy) busy_cyc++;
      end
      prev = cur;
      prev_cen = cen;
      prev_rst = rst;
    end
  end

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] model_mask(input bit is_push, input logic [7:0] pb,
      input logic pall, pcc, ppc, rcc, roth, ce);
    if (is_push) return pall ? 8'hFF : (pb | (ppc ? 8'h80 : 8'h00) | (pcc ? 8'h01 : 8'h00));
    if (rcc) return 8'h01;
    if (roth) return ce ? 8'hFE : 8'h80;
    return pb;
  endfunction

  // Registers 4..7 are 16 bits. Push PC-first with the low byte at the higher address;
  // pull CC-first, high byte from the lower address.
  task automatic build_model(input bit is_push, input logic [7:0] m, input logic [15:0] s);
    logic [15:0] p, v;
    p = s;
    if (is_push) begin
      for (int b = 7; b >= 0; b--) if (m[b]) begin
        v = reg_val[b];
        p = p - 16'd1;
        exp_q.push_back({1'b1, p, v[7:0]});
        if (b >= 4) begin
          p = p - 16'd1;
          exp_q.push_back({1'b1, p, v[15:8]});
        end
      end
    end else begin
      for (int b = 0; b < 8; b++) if (m[b]) begin
        v = 16'h0000;
        if (b >= 4) begin
          v[15:8] = mem[p];
          exp_q.push_back({1'b0, p, 8'h00});
          p = p + 16'd1;
        end
        v[7:0] = mem[p];
        exp_q.push_back({1'b0, p, 8'h00});
        p = p + 16'd1;
        exp_r.push_back({3'(b), v});
      end
    end
    exp_sp = p;
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_go(input bit is_push, input logic [7:0] pb,
      input logic pall, pcc, ppc, rcc, roth, ce, input logic [15:0] sp_v);
    @(posedge clk);
    #1;
    chk("idle_before_go", 64'(stack_busy), 64'd0);
    postbyte = pb; psh_all = pall; psh_cc = pcc; psh_pc = ppc;
    rti_cc = rcc; rti_other = roth; cc_e = ce; sp = sp_v;
    if (is_push) psh_go = 1'b1; else pul_go = 1'b1;
    do @(posedge clk); while (!cen);
    #1;
    psh_go = 1'b0;
    pul_go = 1'b0;
    @(negedge clk);
    chk("busy_rise", 64'(stack_busy), 64'd1);
  endtask

  task automatic do_txn(input bit is_push, input logic [7:0] pb,
      input logic pall, pcc, ppc, rcc, roth, ce, input logic [15:0] sp_v, input bit poke);
    int w0, r0, g0, b0, dn0, cyc;
    for (int i = 0; i < 8; i++) pulled[i] = 16'h0000;
    build_model(is_push, model_mask(is_push, pb, pall, pcc, ppc, rcc, roth, ce), sp_v);
    w0 = n_wr; r0 = n_rd; g0 = n_rwe; b0 = busy_cyc; dn0 = n_done;
    pulse_go(is_push, pb, pall, pcc, ppc, rcc, roth, ce, sp_v);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      postbyte = 8'h01; psh_go = 1'b1; pul_go = 1'b1;
      @(posedge clk);
      #1;
      psh_go = 1'b0; pul_go = 1'b0;
    end
    cyc = 0;
    while (n_done == dn0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk("txn_finished", 64'(n_done - dn0), 64'd1);
    repeat (2) @(negedge clk);
    chk("acc_left", 64'(exp_q.size()), 64'd0);
    chk("reg_left", 64'(exp_r.size()), 64'd0);
    chk("busy_fall", 64'(stack_busy), 64'd0);
    exp_q.delete();
    exp_r.delete();
    d_wr = n_wr - w0; d_rd = n_rd - r0; d_rwe = n_rwe - g0; d_busy = busy_cyc - b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int b_w0, b_w3, w0, dn0, cyc;
    rst = 1'b1;
    psh_go = 0; pul_go = 0; psh_all = 0; psh_cc = 0; psh_pc = 0;
    rti_cc = 0; rti_other = 0; cc_e = 0; use_u = 0; postbyte = 8'h00; sp = 16'h0000;
    reg_val[0] = 16'h00C1; reg_val[1] = 16'h00A2; reg_val[2] = 16'h00B3; reg_val[3] = 16'h00D4;
    reg_val[4] = 16'h1234; reg_val[5] = 16'h5678; reg_val[6] = 16'h9ABC; reg_val[7] = 16'hDEF0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) pulled[i] = 16'h0000;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_busy", 64'(stack_busy), 64'd0);
    chk("rst_we", 64'(bus.we), 64'd0);
    chk("rst_rd", 64'(bus.rd), 64'd0);
    chk("rst_addr", 64'(bus.addr), 64'd0);
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_reg_sel", 64'(reg_sel), 64'd0);
    chk("rst_reg_we", 64'(reg_we), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_sp_we", 64'(sp_we), 64'd0);
    chk("rst_nx_sp", 64'(nx_sp), 64'd0);
    chk("rst_state", 64'(dbg.state), 64'(ST_IDLE));
    chk("rst_mask", 64'(dbg.mask), 64'd0);

    // PSHS PC,B,A from 1000
    do_txn(1, 8'h86, 0, 0, 0, 0, 0, 0, 16'h1000, 0);
    chk("t1_writes", 64'(d_wr), 64'd4);
    chk("t1_sp", 64'(last_sp), 64'h0FFC);
    chk("t1_pclo", 64'(mem[16'h0FFF]), 64'hF0);
    chk("t1_pchi", 64'(mem[16'h0FFE]), 64'hDE);
    chk("t1_b", 64'(mem[16'h0FFD]), 64'hB3);
    chk("t1_a", 64'(mem[16'h0FFC]), 64'hA2);

    // PULS PC,B,A from 0FFC
    do_txn(0, 8'h86, 0, 0, 0, 0, 0, 0, 16'h0FFC, 0);
    chk("t2_reg_we", 64'(d_rwe), 64'd3);
    chk("t2_reads", 64'(d_rd), 64'd4);
    chk("t2_sp", 64'(last_sp), 64'h1000);
    chk("t2_a", 64'(pulled[1]), 64'h00A2);
    chk("t2_b", 64'(pulled[2]), 64'h00B3);
    chk("t2_pc", 64'(pulled[7]), 64'hDEF0);

    // interrupt entry at 0004, wraps through FFFF
    use_u = 1'b1;
    do_txn(1, 8'h00, 1, 0, 0, 0, 0, 0, 16'h0004, 0);
    use_u = 1'b0;
    chk("t3_writes", 64'(d_wr), 64'd12);
    chk("t3_sp", 64'(last_sp), 64'hFFF8);
    chk("t3_osp_hi", 64'(mem[16'h0000]), 64'h9A);
    chk("t3_y_lo", 64'(mem[16'hFFFF]), 64'h78);
    chk("t3_cc", 64'(mem[16'hFFF8]), 64'hC1);
    chk("t3_use_u", 64'(dbg.use_u), 64'd1);

    // RTI: CC, then the rest with E=1, then PC only with E=0
    do_txn(0, 8'h00, 0, 0, 0, 1, 0, 0, 16'hFFF8, 0);
    chk("t4_cc_reads", 64'(d_rd), 64'd1);
    chk("t4_cc", 64'(pulled[0]), 64'h00C1);
    chk("t4_cc_sp", 64'(last_sp), 64'hFFF9);
    do_txn(0, 8'h00, 0, 0, 0, 0, 1, 1, 16'hFFF9, 0);
    chk("t4_e1_reads", 64'(d_rd), 64'd11);
    chk("t4_e1_x", 64'(pulled[4]), 64'h1234);
    chk("t4_e1_osp", 64'(pulled[6]), 64'h9ABC);
    chk("t4_e1_sp", 64'(last_sp), 64'h0004);
    do_txn(0, 8'h00, 0, 0, 0, 0, 1, 0, 16'h0002, 0);
    chk("t4_e0_reads", 64'(d_rd), 64'd2);
    chk("t4_e0_pc", 64'(pulled[7]), 64'hDEF0);
    chk("t4_e0_sp", 64'(last_sp), 64'h0004);

    // empty mask: two busy cycles, no bus traffic, pointer unchanged
    do_txn(1, 8'h00, 0, 0, 0, 0, 0, 0, 16'h1234, 0);
    chk("empty_busy", 64'(d_busy), 64'd2);
    chk("empty_acc", 64'(d_wr + d_rd), 64'd0);
    chk("empty_sp", 64'(last_sp), 64'h1234);

    // wait states: 5 bytes (PC,B,A + psh_cc) with and without 3 busy cycles each
    do_txn(1, 8'h06, 0, 1, 1, 0, 0, 0, 16'h2000, 0);
    b_w0 = d_busy;
    wait_n = 3;
    do_txn(1, 8'h06, 0, 1, 1, 0, 0, 0, 16'h2000, 0);
    b_w3 = d_busy;
    wait_n = 0;
    chk("wait_writes", 64'(d_wr), 64'd5);
    chk("wait_extension", 64'(b_w3 - b_w0), 64'd15);
    chk("wait_sp", 64'(last_sp), 64'h1FFB);

    // go pulses while busy are ignored
    do_txn(1, 8'h00, 1, 0, 0, 0, 0, 0, 16'h5000, 1);
    chk("poke_writes", 64'(d_wr), 64'd12);
    chk("poke_sp", 64'(last_sp), 64'h4FF4);

    // clock-enable gaps with one wait state: push PC,Y,X,B then pull them back
    cen_rand = 1; wait_n = 1;
    do_txn(1, 8'h34, 0, 0, 1, 0, 0, 0, 16'h4000, 0);
    chk("cen_push_sp", 64'(last_sp), 64'h3FF9);
    do_txn(0, 8'hB4, 0, 0, 0, 0, 0, 0, 16'h3FF9, 0);
    chk("cen_pull_sp", 64'(last_sp), 64'h4000);
    chk("cen_pull_x", 64'(pulled[4]), 64'h1234);
    chk("cen_pull_y", 64'(pulled[5]), 64'h5678);
    chk("cen_pull_pc", 64'(pulled[7]), 64'hDEF0);
    cen_rand = 0; wait_n = 0;
    repeat (3) @(posedge clk);

    // reset during the third push byte
    wait_n = 3;
    build_model(1, 8'h86, 16'h3000);
    w0 = n_wr; dn0 = n_done;
    pulse_go(1, 8'h86, 0, 0, 0, 0, 0, 0, 16'h3000);
    cyc = 0;
    while (!(bus.we && bus.addr == 16'h2FFD) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached", 64'(bus.we && bus.addr == 16'h2FFD), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(stack_busy), 64'd0);
    chk("abort_we", 64'(bus.we), 64'd0);
    chk("abort_addr", 64'(bus.addr), 64'd0);
    chk("abort_reg_sel", 64'(reg_sel), 64'd0);
    chk("abort_nx_sp", 64'(nx_sp), 64'd0);
    chk("abort_left", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("abort_no_sp_we", 64'(n_done - dn0), 64'd0);
    chk("abort_writes", 64'(n_wr - w0), 64'd2);
    chk("abort_pclo", 64'(mem[16'h2FFF]), 64'hF0);
    chk("abort_pchi", 64'(mem[16'h2FFE]), 64'hDE);
    chk("abort_b_unwritten", 64'(mem[16'h2FFD]), 64'h00);
    wait_n = 0;
    do_txn(1, 8'h86, 0, 0, 0, 0, 0, 0, 16'h3000, 0);
    chk("after_abort_b", 64'(mem[16'h2FFD]), 64'hB3);
    chk("after_abort_sp", 64'(last_sp), 64'h2FFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
